// File: rtl/riscv_tcm_pkg.sv
// rtl/riscv_tcm_pkg.sv - shared types, defaults and ALU helper for the core + TCM slice
// Purpose: TCM size/base defaults, RV32I opcode and CSR constants, memory-port
//          request/response structs shared by riscv_core and tcm_mem, core FSM states.
// Ports:   none (package).
package riscv_tcm_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned TCM_BYTES_DEF = 131072;
  localparam logic [31:0] TCM_BASE_DEF  = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_SIM_FINISH = 12'h7C0;

  typedef struct packed {
    logic            req;
    logic [XLEN-1:0] addr;
  } fetch_req_t;

  typedef struct packed {
    logic            req;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] rdata;
  } mem_rsp_t;

  typedef enum logic [1:0] {
    S_FETCH,
    S_FWAIT,
    S_EXEC,
    S_MWAIT
  } core_state_t;

  // alt selects SUB for funct3=0 and arithmetic shift for funct3=5
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0:    r = alt ? (a - b) : (a + b);
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'b0, $signed(a) < $signed(b)};
      3'd3:    r = {31'b0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_core.sv
// rtl/riscv_core.sv - compact multi-cycle RV32I core for the TCM slice
// Purpose: fetch -> wait -> execute [-> memory wait] per instruction; RV32I integer ops,
//          loads/stores of byte/half/word, CSR ops on mip and the sim_finish CSR.
// Ports:   clk, rst (async, active-high), intr_i (visible in mip.MEIP)
//          ifetch_req/ifetch_rsp, dmem_req/dmem_rsp : TCM ports
//          sim_finish_o : sticky end-of-test flag, set by writing bit0=1 to CSR 0x7C0
module riscv_core
  import riscv_tcm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       intr_i,
  output fetch_req_t ifetch_req,
  input  mem_rsp_t   ifetch_rsp,
  output dmem_req_t  dmem_req,
  input  mem_rsp_t   dmem_rsp,
  output logic       sim_finish_o
);

  core_state_t state, state_next;
  logic [31:0] pc, pc_next, ir;
  logic [31:0] regs [32];
  logic        sim_finish, set_finish;
  logic        rd_we, take;
  logic [31:0] rd_wdata;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [31:0] a, b, mem_addr, ld_shift, ld_val, csr_rdata, csr_src;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign i_imm  = {{20{ir[31]}}, ir[31:20]};
  assign s_imm  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign b_imm  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign u_imm  = {ir[31:12], 12'b0};
  assign j_imm  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // x0 is never written and resets to zero, so no read-side special case
  assign a        = regs[rs1];
  assign b        = regs[rs2];
  assign mem_addr = a + ((opcode == OP_STORE) ? s_imm : i_imm);
  assign ld_shift = dmem_rsp.rdata >> {mem_addr[1:0], 3'b000};
  assign csr_src  = f3[2] ? {27'b0, rs1} : a;
  assign csr_rdata = (ir[31:20] == CSR_MIP)        ? {20'b0, intr_i, 11'b0} :
                     (ir[31:20] == CSR_SIM_FINISH) ? {31'b0, sim_finish} : 32'b0;
  assign sim_finish_o = sim_finish;

  always_comb begin
    case (f3)
      3'd0:    take = (a == b);
      3'd1:    take = (a != b);
      3'd4:    take = ($signed(a) < $signed(b));
      3'd5:    take = ($signed(a) >= $signed(b));
      3'd6:    take = (a < b);
      3'd7:    take = (a >= b);
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    case (f3)
      3'd0:    ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'd1:    ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'd4:    ld_val = {24'b0, ld_shift[7:0]};
      3'd5:    ld_val = {16'b0, ld_shift[15:0]};
      default: ld_val = ld_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ifetch_req = '0;
    dmem_req   = '0;
    pc_next    = pc;
    rd_we      = 1'b0;
    rd_wdata   = 32'b0;
    set_finish = 1'b0;
    case (state)
      S_FETCH: begin
        ifetch_req.req  = 1'b1;
        ifetch_req.addr = pc;
        state_next      = S_FWAIT;
      end
      S_FWAIT: begin
        if (ifetch_rsp.ack) state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_FETCH;
        pc_next    = pc + 32'd4;
        case (opcode)
          OP_LUI:    begin rd_we = 1'b1; rd_wdata = u_imm; end
          OP_AUIPC:  begin rd_we = 1'b1; rd_wdata = pc + u_imm; end
          OP_JAL:    begin rd_we = 1'b1; rd_wdata = pc + 32'd4; pc_next = pc + j_imm; end
          OP_JALR:   begin rd_we = 1'b1; rd_wdata = pc + 32'd4; pc_next = (a + i_imm) & ~32'd1; end
          OP_BRANCH: if (take) pc_next = pc + b_imm;
          OP_IMM:    begin rd_we = 1'b1; rd_wdata = alu(f3, (f3 == 3'd5) && ir[30], a, i_imm); end
          OP_REG:    begin rd_we = 1'b1; rd_wdata = alu(f3, ir[30], a, b); end
          OP_LOAD: begin
            dmem_req.req  = 1'b1;
            dmem_req.addr = mem_addr;
            pc_next       = pc;
            state_next    = S_MWAIT;
          end
          OP_STORE: begin
            dmem_req.req  = 1'b1;
            dmem_req.we   = 1'b1;
            dmem_req.addr = mem_addr;
            case (f3[1:0])
              2'd0:    begin dmem_req.be = 4'b0001 << mem_addr[1:0]; dmem_req.wdata = {4{b[7:0]}}; end
              2'd1:    begin dmem_req.be = 4'b0011 << mem_addr[1:0]; dmem_req.wdata = {2{b[15:0]}}; end
              default: begin dmem_req.be = 4'b1111; dmem_req.wdata = b; end
            endcase
            pc_next    = pc;
            state_next = S_MWAIT;
          end
          OP_SYSTEM: begin
            if (f3[1:0] != 2'd0) begin
              rd_we      = 1'b1;
              rd_wdata   = csr_rdata;
              set_finish = (ir[31:20] == CSR_SIM_FINISH) && (f3[1:0] != 2'd3) && csr_src[0];
            end
          end
          default: ;
        endcase
      end
      S_MWAIT: begin
        if (dmem_rsp.ack) begin
          state_next = S_FETCH;
          pc_next    = pc + 32'd4;
          rd_we      = (opcode == OP_LOAD);
          rd_wdata   = ld_val;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      ir         <= 32'b0;
      sim_finish <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'b0;
    end else begin
      pc <= pc_next;
      if (state == S_FWAIT && ifetch_rsp.ack) ir <= ifetch_rsp.rdata;
      if (rd_we && rd != 5'd0) regs[rd] <= rd_wdata;
      if (set_finish) sim_finish <= 1'b1;
    end
  end

endmodule

// File: rtl/tcm_mem.sv
// rtl/tcm_mem.sv - dual-port byte-lane TCM: 1R fetch port, 1RW data port, backdoor access
// Purpose: single-cycle RAM; a request sampled at a clock edge is acked with its read
//          data for the following cycle. Reads return the word as it was before any
//          write at the same edge. Contents survive rst; only the response flops clear.
// Ports:   clk, rst (async, active-high)
//          ifetch_req / ifetch_rsp : instruction read port (addr is byte offset into TCM)
//          dmem_req   / dmem_rsp   : data read/write port with byte enables
// Backdoor: write(byte_addr, data) and read(byte_addr), addresses wrap modulo BYTES.
module tcm_mem
  import riscv_tcm_pkg::*;
#(
  parameter int unsigned BYTES = TCM_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  fetch_req_t ifetch_req,
  output mem_rsp_t   ifetch_rsp,
  input  dmem_req_t  dmem_req,
  output mem_rsp_t   dmem_rsp
);

  localparam int unsigned AW    = $clog2(BYTES);
  localparam int unsigned IW    = (AW > 2) ? AW - 2 : 1;
  localparam int unsigned WORDS = BYTES / 4;

  logic [31:0]   mem [WORDS];
  logic [IW-1:0] f_idx;
  logic [IW-1:0] d_idx;

  // Dropping addr[1:0] and masking to the array size gives aligned, wrapping word indices
  assign f_idx = IW'((ifetch_req.addr >> 2) & 32'(WORDS - 1));
  assign d_idx = IW'((dmem_req.addr >> 2) & 32'(WORDS - 1));

  // Plain always: the backdoor task also writes this array
  always @(posedge clk) begin
    if (!rst && dmem_req.req && dmem_req.we) begin
      for (int k = 0; k < 4; k++) begin
        if (dmem_req.be[k]) mem[d_idx][8*k +: 8] <= dmem_req.wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifetch_rsp <= '0;
      dmem_rsp   <= '0;
    end else begin
      ifetch_rsp.ack   <= ifetch_req.req;
      ifetch_rsp.rdata <= ifetch_req.req ? mem[f_idx] : '0;
      dmem_rsp.ack     <= dmem_req.req;
      dmem_rsp.rdata   <= dmem_req.req ? mem[d_idx] : '0;
    end
  end

  task automatic write(input logic [31:0] byte_addr, input logic [7:0] data);
    logic [31:0] off;
    off = byte_addr & 32'(BYTES - 1);
    mem[IW'(off >> 2)][{off[1:0], 3'b000} +: 8] <= data;
  endtask

  function automatic logic [7:0] read(input logic [31:0] byte_addr);
    logic [31:0] off;
    off = byte_addr & 32'(BYTES - 1);
    return mem[IW'(off >> 2)][{off[1:0], 3'b000} +: 8];
  endfunction

endmodule

// File: rtl/riscv_tcm_top.sv
// rtl/riscv_tcm_top.sv - RISC-V core tightly coupled to a shared instruction/data TCM
// Purpose: riscv_core (u_dut) + tcm_mem (u_mem); glue only rebases core addresses to
//          TCM byte offsets (wrap is handled inside the TCM).
// Ports:   clk, rst (async, active-high), intr_i (level interrupt into core),
//          sim_finish_o (core end-of-test flag, combinational pass-through)
module riscv_tcm_top
  import riscv_tcm_pkg::*;
#(
  parameter int unsigned TCM_BYTES   = TCM_BYTES_DEF,
  parameter logic [31:0] TCM_BASE    = TCM_BASE_DEF,
  parameter logic [31:0] BOOT_VECTOR = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic intr_i,
  output logic sim_finish_o
);

  fetch_req_t core_ifetch_req, tcm_ifetch_req;
  dmem_req_t  core_dmem_req, tcm_dmem_req;
  mem_rsp_t   ifetch_rsp, dmem_rsp;

  riscv_core #(.RESET_PC(BOOT_VECTOR)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .intr_i       (intr_i),
    .ifetch_req   (core_ifetch_req),
    .ifetch_rsp   (ifetch_rsp),
    .dmem_req     (core_dmem_req),
    .dmem_rsp     (dmem_rsp),
    .sim_finish_o (sim_finish_o)
  );

  always_comb begin
    tcm_ifetch_req      = core_ifetch_req;
    tcm_ifetch_req.addr = core_ifetch_req.addr - TCM_BASE;
    tcm_dmem_req        = core_dmem_req;
    tcm_dmem_req.addr   = core_dmem_req.addr - TCM_BASE;
  end

  tcm_mem #(.BYTES(TCM_BYTES)) u_mem (
    .clk        (clk),
    .rst        (rst),
    .ifetch_req (tcm_ifetch_req),
    .ifetch_rsp (ifetch_rsp),
    .dmem_req   (tcm_dmem_req),
    .dmem_rsp   (dmem_rsp)
  );

endmodule

// File: tb/tb_riscv_tcm_top.sv
// tb/tb_riscv_tcm_top.sv - self-checking bench for riscv_tcm_top and its TCM
module tb_riscv_tcm_top;
  import riscv_tcm_pkg::*;

  logic       clk;
  logic       top_rst, tcm_rst, intr;
  logic       sim_finish;
  fetch_req_t f_req;
  dmem_req_t  d_req;
  mem_rsp_t   f_rsp, d_rsp;

  int checks;
  int failures;

  logic [7:0]  model [int];
  logic [31:0] prog  [16];

  riscv_tcm_top u_top (
    .clk          (clk),
    .rst          (top_rst),
    .intr_i       (intr),
    .sim_finish_o (sim_finish)
  );

  tcm_mem u_tcm (
    .clk        (clk),
    .rst        (tcm_rst),
    .ifetch_req (f_req),
    .ifetch_rsp (f_rsp),
    .dmem_req   (d_req),
    .dmem_rsp   (d_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    f_req = '0;
    d_req = '0;
  endtask

  task automatic dwrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    d_req = '{req: 1'b1, we: 1'b1, be: be, addr: addr, wdata: data};
  endtask

  task automatic dread(input logic [31:0] addr);
    d_req = '{req: 1'b1, we: 1'b0, be: 4'b0, addr: addr, wdata: 32'b0};
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int base;
    base = int'(a & 32'h0001_FFFC);
    return {model[base+3], model[base+2], model[base+1], model[base]};
  endfunction

  // Window 0x400..0x43F, with random multiples of the TCM size added to exercise wrap
  function automatic logic [31:0] rand_addr();
    return 32'h400 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
         | (32'($urandom_range(0, 7)) << 17);
  endfunction

  initial begin
    logic [31:0] w, exp_f, exp_d, exp_sum, exp_x29;
    int          base;
    checks   = 0;
    failures = 0;
    top_rst  = 1'b1;
    tcm_rst  = 1'b1;
    intr     = 1'b0;
    idle();

    prog = '{32'h00A00293, 32'h00000E93, 32'h005E8EB3, 32'hFFF28293,
             32'hFE029CE3, 32'h00001337, 32'h01D32023, 32'h0AB00413,
             32'h008300A3, 32'h00032383, 32'h00134483, 32'h00849663,
             32'h00100E13, 32'h00038EB3, 32'h7C00D073, 32'h0000006F};

    repeat (2) @(posedge clk);
    #2;
    check("rst_sim_finish", {31'b0, sim_finish}, 32'd0);
    check("rst_f_ack", {31'b0, f_rsp.ack}, 32'd0);
    check("rst_f_rdata", f_rsp.rdata, 32'd0);
    check("rst_d_ack", {31'b0, d_rsp.ack}, 32'd0);
    check("rst_d_rdata", d_rsp.rdata, 32'd0);

    // Program: sum 10..1 into x29, store it at 0x1000, overwrite byte 1 with 0xAB,
    // reload; x28=1 when the byte reads back, then set sim_finish and spin.
    for (int i = 0; i < 16; i++) begin
      w = prog[i];
      for (int k = 0; k < 4; k++) u_top.u_mem.write(32'(4 * i + k), w[8*k +: 8]);
    end
    repeat (5) @(posedge clk);
    #2;
    top_rst = 1'b0;

    exp_sum = 0;
    for (int n = 1; n <= 10; n++) exp_sum += 32'(n);
    exp_x29 = exp_sum | (32'hAB << 8);

    for (int i = 0; i < 4000 && sim_finish !== 1'b1; i++) @(posedge clk);
    #2;
    check("core_sim_finish", {31'b0, sim_finish}, 32'd1);
    check("core_x28_pass", u_top.u_dut.regs[28], 32'd1);
    check("core_x29_result", u_top.u_dut.regs[29], exp_x29);
    $display("core result x29=0x%h", u_top.u_dut.regs[29]);

    tcm_rst = 1'b0;
    cycle();

    // fetch latency: ack exactly one cycle
    u_tcm.write(32'h0, 8'h13);
    u_tcm.write(32'h1, 8'h00);
    u_tcm.write(32'h2, 8'h00);
    u_tcm.write(32'h3, 8'h00);
    f_req = '{req: 1'b1, addr: 32'h0};
    cycle();
    check("fetch_ack", {31'b0, f_rsp.ack}, 32'd1);
    check("fetch_rdata", f_rsp.rdata, 32'h0000_0013);
    idle();
    cycle();
    check("fetch_ack_one_cycle", {31'b0, f_rsp.ack}, 32'd0);

    // byte-lane write over zero
    dwrite(32'h100, 32'h0, 4'hF);
    cycle();
    dwrite(32'h100, 32'hDEAD_BEEF, 4'b0101);
    cycle();
    check("be_write_ack", {31'b0, d_rsp.ack}, 32'd1);
    check("be_write_old", d_rsp.rdata, 32'h0);
    dread(32'h100);
    cycle();
    check("be_write_read", d_rsp.rdata, 32'h00AD_00EF);

    // same-cycle fetch read and data write to one word
    for (int k = 0; k < 4; k++) u_tcm.write(32'h200 + 32'(k), 8'h11);
    #1;
    f_req = '{req: 1'b1, addr: 32'h200};
    dwrite(32'h200, 32'h2222_2222, 4'hF);
    cycle();
    check("collide_fetch_old", f_rsp.rdata, 32'h1111_1111);
    check("collide_data_old", d_rsp.rdata, 32'h1111_1111);
    idle();
    dread(32'h200);
    cycle();
    check("collide_write_landed", d_rsp.rdata, 32'h2222_2222);

    // wrap at TCM size
    dwrite(32'h2_0000, 32'hCAFE_F00D, 4'hF);
    cycle();
    dread(32'h0);
    cycle();
    check("wrap_read", d_rsp.rdata, 32'hCAFE_F00D);

    // be=0 write: acked, no effect
    dwrite(32'h0, 32'h1234_5678, 4'b0000);
    cycle();
    check("be0_ack", {31'b0, d_rsp.ack}, 32'd1);
    dread(32'h0);
    cycle();
    check("be0_noop", d_rsp.rdata, 32'hCAFE_F00D);

    // reset right after a clocked write: ack dropped, write kept
    dwrite(32'h300, 32'h55AA_55AA, 4'hF);
    @(posedge clk);
    #1;
    tcm_rst = 1'b1;
    #1;
    check("rst_mid_ack", {31'b0, d_rsp.ack}, 32'd0);
    check("rst_mid_rdata", d_rsp.rdata, 32'd0);
    idle();
    cycle();
    tcm_rst = 1'b0;
    cycle();
    dread(32'h300);
    cycle();
    check("rst_mid_write_kept", d_rsp.rdata, 32'h55AA_55AA);
    idle();

    // randomized traffic against a byte-array model
    for (int off = 32'h400; off < 32'h440; off++) begin
      w[7:0] = 8'($urandom);
      model[off] = w[7:0];
      u_tcm.write(32'(off) + (32'($urandom_range(0, 3)) << 17), w[7:0]);
    end
    cycle();
    for (int it = 0; it < 300; it++) begin
      f_req.req   = ($urandom_range(0, 1) == 1);
      f_req.addr  = rand_addr();
      d_req.req   = ($urandom_range(0, 3) != 0);
      d_req.we    = ($urandom_range(0, 1) == 1);
      d_req.be    = 4'($urandom_range(0, 15));
      d_req.addr  = rand_addr();
      d_req.wdata = $urandom;
      exp_f = model_word(f_req.addr);
      exp_d = model_word(d_req.addr);
      cycle();
      check("rnd_f_ack", {31'b0, f_rsp.ack}, {31'b0, f_req.req});
      check("rnd_d_ack", {31'b0, d_rsp.ack}, {31'b0, d_req.req});
      if (f_req.req) check("rnd_f_rdata", f_rsp.rdata, exp_f);
      if (d_req.req) check("rnd_d_rdata", d_rsp.rdata, exp_d);
      if (d_req.req && d_req.we) begin
        base = int'(d_req.addr & 32'h0001_FFFC);
        for (int k = 0; k < 4; k++)
          if (d_req.be[k]) model[base+k] = d_req.wdata[8*k +: 8];
      end
    end
    idle();
    cycle();
    for (int off = 32'h400; off < 32'h440; off++)
      check("rnd_backdoor_byte", {24'b0, u_tcm.read(32'(off))}, {24'b0, model[off]});

    // top reset while running: flag clears, TCM contents survive
    top_rst = 1'b1;
    #2;
    check("top_rst_sim_finish", {31'b0, sim_finish}, 32'd0);
    check("top_rst_prog_kept", {24'b0, u_top.u_mem.read(32'h0)}, 32'h93);
    check("top_rst_data_kept", {24'b0, u_top.u_mem.read(32'h1001)}, 32'hAB);
    cycle();
    check("top_rst_sim_finish_held", {31'b0, sim_finish}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
